piccolo_rk_seq: RTL and testbench

PICCOLO_RK_SEQ -- requirements
Module: piccolo_rk_seq

---
 rtl/piccolo_pkg.sv | 17 +
 rtl/piccolo_con80.sv | 17 +
 rtl/piccolo_rk_seq.sv | 140 ++++++++++++++
 tb/tb_piccolo_rk_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/piccolo_pkg.sv
// Shared definitions for the Piccolo-80 round-key sequencer.
//   ROUNDS_DEFAULT : number of round-key pairs produced per key
//   WORD_W         : width of one key word / round key
//   CON_MASK       : constant XORed into every con pair
//   state_e        : sequencer FSM states
package piccolo_pkg;

  localparam int          ROUNDS_DEFAULT = 25;
  localparam int          WORD_W         = 16;
  localparam logic [31:0] CON_MASK       = 32'h0F1E2D3C;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/piccolo_con80.sv
// Piccolo-80 round constant generator (purely combinational).
//   round_i : round index i (0-based)
//   con_o   : {con_2i, con_2i+1}
module piccolo_con80
  import piccolo_pkg::*;
(
  input  logic [4:0]  round_i,
  output logic [31:0] con_o
);

  // The constant is built from the 1-based round number.
  logic [4:0] c_n;

  assign c_n   = round_i + 5'd1;
  assign con_o = {c_n, 5'd0, c_n, 2'b00, c_n, 5'd0, c_n} ^ CON_MASK;

endmodule

// File: rtl/piccolo_rk_seq.sv
// Piccolo-80 key schedule sequencer.
// Registers an 80-bit key on start and then streams one round-key pair per
// accepted handshake, ROUNDS pairs in total, followed by a one-cycle done.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, key : begin a schedule with key (sampled only in IDLE)
//   abort      : cancel a running schedule (no done pulse)
//   busy       : high while the schedule runs
//   wk_o       : whitening keys {wk3, wk2, wk1, wk0}
//   rk_valid, rk_ready, rk_o, round_o : round-key stream and its index
//   done       : one-cycle pulse after the last pair is accepted
module piccolo_rk_seq
  import piccolo_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [79:0] key,
  input  logic        abort,
  output logic        busy,
  output logic [63:0] wk_o,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [31:0] rk_o,
  output logic [4:0]  round_o,
  output logic        done
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  logic [79:0] key_q,   key_d;
  logic        done_q,  done_d;

  // Split the registered key into k0..k4 (k0 is the most significant word).
  logic [WORD_W-1:0] k_w [5];

  for (genvar gi = 0; gi < 5; gi++) begin : g_key_words
    assign k_w[gi] = key_q[79 - WORD_W*gi -: WORD_W];
  end

  // Whitening keys depend only on the key register, so they stay put for
  // the whole schedule and afterwards until the next accepted start.
  assign wk_o = {k_w[3][15:8], k_w[4][7:0],
                 k_w[4][15:8], k_w[3][7:0],
                 k_w[1][15:8], k_w[0][7:0],
                 k_w[0][15:8], k_w[1][7:0]};

  // Round-key datapath: selected key words XOR round constant.
  logic [31:0]       con_pair;
  logic [2:0]        round_mod5;
  logic [WORD_W-1:0] sel_hi, sel_lo;

  piccolo_con80 u_con (
    .round_i (round_q),
    .con_o   (con_pair)
  );

  assign round_mod5 = 3'(round_q % 5'd5);

  always_comb begin
    sel_hi = k_w[2];
    sel_lo = k_w[3];
    case (round_mod5)
      3'd1, 3'd4: begin
        sel_hi = k_w[0];
        sel_lo = k_w[1];
      end
      3'd3: begin
        sel_hi = k_w[4];
        sel_lo = k_w[4];
      end
      default: begin
        sel_hi = k_w[2];
        sel_lo = k_w[3];
      end
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign rk_valid = busy;
  assign done     = done_q;
  // round_q is already 0 whenever the FSM is idle.
  assign round_o  = round_q;
  assign rk_o     = busy ? {sel_hi ^ con_pair[31:16], sel_lo ^ con_pair[15:0]}
                         : 32'd0;

  // Next-state logic. Abort wins over a simultaneous transfer; start is
  // looked at only while idle, so the key cannot change mid-schedule.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          round_d = 5'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          round_d = 5'd0;
        end else if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            state_d = ST_IDLE;
            round_d = 5'd0;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= 5'd0;
      key_q   <= 80'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_piccolo_rk_seq.sv
// Directed testbench for piccolo_rk_seq.
module tb_piccolo_rk_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [79:0] key = 80'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic [63:0] wk_o;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic [31:0] rk_o;
  logic [4:0]  round_o;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  localparam logic [79:0] K1 = 80'h00112233445566778899;
  localparam logic [79:0] K2 = 80'h0123456789ABCDEF0011;
  localparam logic [79:0] K3 = 80'hFEDCBA98765432100F0F;

  piccolo_rk_seq #(.ROUNDS(25)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .abort    (abort),
    .busy     (busy),
    .wk_o     (wk_o),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_o     (rk_o),
    .round_o  (round_o),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Reference round key: con placed at bit offsets 27/17/10/0, key words
  // chosen by round mod 5.
  function automatic logic [31:0] ref_rk(input logic [79:0] k, input int r);
    logic [31:0] c, con;
    logic [15:0] hi, lo;
    c   = 32'(r + 1);
    con = ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h0F1E2D3C;
    case (r % 5)
      1, 4:    begin hi = k[79:64]; lo = k[63:48]; end
      3:       begin hi = k[15:0];  lo = k[15:0];  end
      default: begin hi = k[47:32]; lo = k[31:16]; end
    endcase
    return {hi, lo} ^ con;
  endfunction

  function automatic logic [63:0] ref_wk(input logic [79:0] k);
    logic [7:0] k0h, k0l, k1h, k1l, k3h, k3l, k4h, k4l;
    k0h = k[79:72]; k0l = k[71:64];
    k1h = k[63:56]; k1l = k[55:48];
    k3h = k[31:24]; k3l = k[23:16];
    k4h = k[15:8];  k4l = k[7:0];
    return {k3h, k4l, k4h, k3l, k1h, k0l, k0h, k1l};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 80'(busy), 80'(0));
    check({tag, ".rk_valid"}, 80'(rk_valid), 80'(0));
    check({tag, ".rk_o"}, 80'(rk_o), 80'(0));
    check({tag, ".round_o"}, 80'(round_o), 80'(0));
  endtask

  task automatic check_round(input string tag, input logic [79:0] k, input int r);
    check({tag, ".round_o"}, 80'(round_o), 80'(r));
    check({tag, ".rk_o"}, 80'(rk_o), 80'(ref_rk(k, r)));
    check({tag, ".rk_valid"}, 80'(rk_valid), 80'(1));
    check({tag, ".done"}, 80'(done), 80'(0));
  endtask

  initial begin
    // Reset state
    #3;
    check_idle("reset");
    check("reset.wk_o", 80'(wk_o), 80'(0));
    check("reset.done", 80'(done), 80'(0));
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // Full schedule with K1, ready stall at round 7, start+K2 at round 5
    done_base = done_cnt;
    key = K1; start = 1'b1; rk_ready = 1'b0;
    tick();
    start = 1'b0;
    check("k1.busy", 80'(busy), 80'(1));
    check("k1.wk_o", 80'(wk_o), 80'(64'h6699887722110033));
    check("k1.rk0_hand", 80'(rk_o), 80'(32'h43494F4A));
    for (int r = 0; r < 25; r++) begin
      check_round($sformatf("k1.r%0d", r), K1, r);
      check($sformatf("k1.r%0d.wk_o", r), 80'(wk_o), 80'(64'h6699887722110033));
      if (r == 3) check("k1.rk3_hand", 80'(rk_o), 80'(32'hA78FB5A1));
      if (r == 7) begin
        rk_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_round($sformatf("k1.stall%0d", s), K1, 7);
        end
      end
      if (r == 5) begin
        start = 1'b1;
        key = K2;
      end
      rk_ready = 1'b1;
      tick();
      start = 1'b0;
    end
    check("k1.end.done", 80'(done), 80'(1));
    check_idle("k1.end");
    check("k1.end.wk_o", 80'(wk_o), 80'(64'h6699887722110033));
    tick();
    check("k1.end.done_off", 80'(done), 80'(0));
    check("k1.done_count", 80'(done_cnt - done_base), 80'(1));

    // Abort at round 10 together with a transfer
    done_base = done_cnt;
    key = K1; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 10; r++) begin
      check_round($sformatf("ab.r%0d", r), K1, r);
      tick();
    end
    check_round("ab.r10", K1, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("ab.after");
    check("ab.after.done", 80'(done), 80'(0));
    tick();
    check_idle("ab.after2");
    check("ab.done_count", 80'(done_cnt - done_base), 80'(0));

    // Reset at round 12, then restart with start+abort and a new key
    key = K2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 12; r++) begin
      check_round($sformatf("rs.r%0d", r), K2, r);
      tick();
    end
    check_round("rs.r12", K2, 12);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rs.async");
    check("rs.async.wk_o", 80'(wk_o), 80'(0));
    check("rs.async.done", 80'(done), 80'(0));
    @(posedge clk);
    #4 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check_idle($sformatf("rs.quiet%0d", s));
      check($sformatf("rs.quiet%0d.wk_o", s), 80'(wk_o), 80'(0));
      check($sformatf("rs.quiet%0d.done", s), 80'(done), 80'(0));
    end
    key = K3; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("k3.busy", 80'(busy), 80'(1));
    check("k3.wk_o", 80'(wk_o), 80'(ref_wk(K3)));
    for (int r = 0; r < 6; r++) begin
      check_round($sformatf("k3.r%0d", r), K3, r);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
